// File: rtl/alu_sched_if.sv
// alu_sched_if: request, ALU-steering and response signals of the shared-ALU scheduler.
// The master modport is the requester/ALU/consumer side; the slave modport is the scheduler.
interface alu_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_op1;
  logic [DATA_WIDTH-1:0] req0_op2;
  logic [3:0]            req0_ctrl;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_op1;
  logic [DATA_WIDTH-1:0] req1_op2;
  logic [3:0]            req1_ctrl;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [3:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_op1, alu_op2, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready, alu_op1, alu_op2, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: arbitrates two requesters onto one combinational ALU and captures the
// result in a one-entry valid/ready output register.
// Macro ALU_SCHED_RR_EN: round-robin tie-break; undefined gives fixed priority (port 0 wins).
module alu_sched #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  bus
);

  logic                  slot_free;
  logic                  sel;
  logic [1:0]            grant;
  logic                  accept;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;

`ifdef ALU_SCHED_RR_EN
  logic                  last_q, last_d;
`endif

  // Pick the candidate port and grant it when the output slot can take a result.
  // sel is also used with no grant so the ALU inputs always track a real port.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
`ifdef ALU_SCHED_RR_EN
    if (bus.req0_valid && bus.req1_valid) sel = ~last_q;
    else if (bus.req1_valid)              sel = 1'b1;
    else if (bus.req0_valid)              sel = 1'b0;
    else                                  sel = ~last_q;
`else
    sel = !bus.req0_valid && bus.req1_valid;
`endif
    grant = 2'b00;
    if (slot_free) begin
      if (!sel && bus.req0_valid) grant = 2'b01;
      if ( sel && bus.req1_valid) grant = 2'b10;
    end
    accept = |grant;
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.alu_op1    = sel ? bus.req1_op1  : bus.req0_op1;
  assign bus.alu_op2    = sel ? bus.req1_op2  : bus.req0_op2;
  assign bus.alu_ctrl   = sel ? bus.req1_ctrl : bus.req0_ctrl;

  // Response register: accept overwrites (even while draining), drain alone clears valid.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_result_d = rsp_result_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = sel;
      rsp_zero_d   = (bus.alu_out == '0);
      rsp_result_d = bus.alu_out;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Response state flops; reset discards any pending result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_result_q <= rsp_result_d;
    end
  end

`ifdef ALU_SCHED_RR_EN
  // Remember the last granted port; reset to 1 so port 0 wins the first tie.
  always_comb begin
    last_d = accept ? sel : last_q;
  end

  // Round-robin pointer flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_result = rsp_result_q;

endmodule
